serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_subtractor_subbit.sv | 42 ++++
 rtl/serial_subtractor.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared types and constants for the bit-serial subtractor.
//   - state_t       : controller states (2-bit encoding)
//   - DEFAULT_WIDTH : default operand/result width
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_subbit.sv
// subbit
//   Gate-level 1-bit full subtractor, the counterpart of the 1-bit full adder.
//   Carries specify path delays so path-listing PLI tests can query it.
//   Ports:
//     a     : minuend bit
//     bi_in : borrow-in
//     b     : subtrahend bit
//     diff  : a ^ b ^ bi_in
//     bo    : (~a & b) | (~(a ^ b) & bi_in)
module subbit (
  input  logic a,
  input  logic bi_in,
  input  logic b,
  output logic diff,
  output logic bo
);

  logic axb;
  logic na;
  logic nxb;
  logic t_ab;
  logic t_bi;

  xor g_axb  (axb, a, b);
  xor g_diff (diff, axb, bi_in);
  not g_na   (na, a);
  and g_tab  (t_ab, na, b);
  // A borrow-in propagates only when a and b are equal.
  not g_nxb  (nxb, axb);
  and g_tbi  (t_bi, nxb, bi_in);
  or  g_bo   (bo, t_ab, t_bi);

  specify
    (a     => diff) = 2;
    (b     => diff) = 2;
    (bi_in => diff) = 2;
    (a     => bo)   = 3;
    (b     => bo)   = 3;
    (bi_in => bo)   = 3;
  endspecify

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: in_a - in_b - in_bi, LSB first, one bit
//   per clock through a single gate-level full-subtractor cell (instance s0).
//   Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high; the producer holds data stable while valid is high.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     in_valid/in_ready        : operand handshake (in_a, in_b, in_bi)
//     ser_valid/ser_diff/ser_bo: per-bit difference and borrow-out while shifting
//     out_valid/out_ready      : result handshake (out_diff, out_borrow)
//     busy                     : high whenever not idle
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bi,
  output logic             ser_valid,
  output logic             ser_diff,
  output logic             ser_bo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             busy
);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt;

  logic               cell_diff;
  logic               cell_bo;

  subbit s0 (
    .a     (a_sr[0]),
    .bi_in (borrow_q),
    .b     (b_sr[0]),
    .diff  (cell_diff),
    .bo    (cell_bo)
  );

  // New bit enters at the MSB so bit 0 lands in position 0 after WIDTH shifts.
  // Written as shift/or so WIDTH = 1 needs no special-case slicing.
  logic [WIDTH-1:0] res_next;
  assign res_next = (res_sr >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= in_a;
            b_sr     <= in_b;
            borrow_q <= in_bi;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr   <= res_next;
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          borrow_q <= cell_bo;
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake/status outputs decode directly from the state register.
  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign ser_valid  = (state == SHIFT);
  assign out_valid  = (state == DONE);

  // Cell outputs are only meaningful while shifting; keep them low otherwise.
  assign ser_diff   = ser_valid & cell_diff;
  assign ser_bo     = ser_valid & cell_bo;

  assign out_diff   = res_sr;
  // borrow_q holds the final borrow-out once all bits have been shifted.
  assign out_borrow = out_valid & borrow_q;

endmodule
